// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial pattern detector.
// The config struct is sized for the widest supported pattern (MAX_LEN <= 32).
package seq_det_pkg;

  localparam int CFG_PAT_W = 32;
  localparam int CFG_LEN_W = 6;

  localparam int                 DEF_MAX_LEN   = 8;
  localparam logic [7:0]         DEF_PATTERN_C = 8'b0101_1010;
  localparam int                 DEF_LEN_C     = 7;
  localparam logic               DEF_OVERLAP_C = 1'b1;

  function automatic int lenWidth(input int maxLen);
    return $clog2(maxLen + 1);
  endfunction

  typedef struct packed {
    logic [CFG_PAT_W-1:0] pat;
    logic [CFG_LEN_W-1:0] len;
    logic                 ovl;
  } cfg_t;

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module seq_det_sat_cnt
  import seq_det_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector with a same-cycle Mealy match flag,
// overlap control, runtime config load and a saturating match counter.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int                  MAX_LEN     = DEF_MAX_LEN,
  parameter int                  CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]  DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
  parameter int                  DEF_LEN     = DEF_LEN_C,
  parameter logic                DEF_OVERLAP = DEF_OVERLAP_C,
  localparam int                 LEN_W       = lenWidth(MAX_LEN)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cfg_we,
  input  logic [MAX_LEN-1:0] i_cfg_pattern,
  input  logic [LEN_W-1:0]   i_cfg_len,
  input  logic               i_cfg_overlap,
  input  logic               i_cnt_clr,
  input  logic               i_seq_valid,
  input  logic               i_seq_in,
  output logic               o_flag,
  output logic [CNT_W-1:0]   o_match_cnt,
  output logic               o_cfg_err
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);

  cfg_t                 r_cfg;
  logic [MAX_LEN-2:0]   r_hist;
  logic [LEN_W-1:0]     r_fill;
  logic                 r_cfgErr;

  logic [MAX_LEN-1:0]   w_window;
  logic [CFG_PAT_W-1:0] w_mask;
  logic                 w_patEq;
  logic                 w_filled;
  logic                 w_cfgLegal;

  // Compare only the low len bits: window and pattern are both zero-extended.
  assign w_window   = {r_hist, i_seq_in};
  assign w_mask     = (CFG_PAT_W'(1) << r_cfg.len) - CFG_PAT_W'(1);
  assign w_patEq    = ((CFG_PAT_W'(w_window) ^ r_cfg.pat) & w_mask) == '0;
  assign w_filled   = CFG_LEN_W'(r_fill) >= (r_cfg.len - CFG_LEN_W'(1));
  assign w_cfgLegal = (i_cfg_len != '0) && (i_cfg_len <= LEN_W'(MAX_LEN));

  assign o_flag = i_seq_valid & ~i_cfg_we & ~i_rst & w_filled & w_patEq;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cfg    <= '{pat: CFG_PAT_W'(DEF_PATTERN), len: CFG_LEN_W'(DEF_LEN), ovl: DEF_OVERLAP};
      r_hist   <= '0;
      r_fill   <= '0;
      r_cfgErr <= 1'b0;
    end else begin
      r_cfgErr <= i_cfg_we & ~w_cfgLegal;
      if (i_cfg_we) begin
        if (w_cfgLegal) begin
          r_cfg  <= '{pat: CFG_PAT_W'(i_cfg_pattern), len: CFG_LEN_W'(i_cfg_len), ovl: i_cfg_overlap};
          r_fill <= '0;
        end
      end else if (i_seq_valid) begin
        r_hist <= w_window[MAX_LEN-2:0];
        // Non-overlapping mode forgets the matched bits by emptying the history count.
        if (o_flag && !r_cfg.ovl) begin
          r_fill <= '0;
        end else if (r_fill != FILL_MAX) begin
          r_fill <= r_fill + 1'b1;
        end
      end
    end
  end

  assign o_cfg_err = r_cfgErr;

  seq_det_sat_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_clr(i_cnt_clr),
    .i_inc(o_flag),
    .o_cnt(o_match_cnt)
  );

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed bench for seq_det_prog: a default instance plus a 2-bit-counter
// instance sharing the same stimulus.
module tb_seq_det_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfgWe = 1'b0;
  logic [7:0] cfgPattern = '0;
  logic [3:0] cfgLen = '0;
  logic       cfgOverlap = 1'b0;
  logic       cntClr = 1'b0;
  logic       seqValid = 1'b0;
  logic       seqIn = 1'b0;

  logic       flag, flag2;
  logic [7:0] cnt;
  logic [1:0] cnt2;
  logic       cfgErr, cfgErr2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_det_prog dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_we(cfgWe), .i_cfg_pattern(cfgPattern),
    .i_cfg_len(cfgLen), .i_cfg_overlap(cfgOverlap), .i_cnt_clr(cntClr),
    .i_seq_valid(seqValid), .i_seq_in(seqIn),
    .o_flag(flag), .o_match_cnt(cnt), .o_cfg_err(cfgErr)
  );

  seq_det_prog #(.CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_cfg_we(cfgWe), .i_cfg_pattern(cfgPattern),
    .i_cfg_len(cfgLen), .i_cfg_overlap(cfgOverlap), .i_cnt_clr(cntClr),
    .i_seq_valid(seqValid), .i_seq_in(seqIn),
    .o_flag(flag2), .o_match_cnt(cnt2), .o_cfg_err(cfgErr2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle, checks the Mealy flag mid-cycle, then releases one-shot controls.
  task automatic applyStimulus(input logic v, input logic s, input logic expFlag, input string tag);
    seqValid = v;
    seqIn    = s;
    #3;
    checkOutput({tag, "/flag"}, {31'b0, flag}, {31'b0, expFlag});
    checkOutput({tag, "/flag2"}, {31'b0, flag2}, {31'b0, expFlag});
    @(posedge clk);
    #1;
    rst      = 1'b0;
    cfgWe    = 1'b0;
    cntClr   = 1'b0;
    seqValid = 1'b0;
    seqIn    = 1'b0;
  endtask

  initial begin
    logic [11:0] stream12;
    logic [11:0] expOvl;
    logic [11:0] expNov;
    logic [9:0]  stream10;
    logic [9:0]  exp10;
    logic [6:0]  stream7;

    stream12 = 12'b1011_0101_1010;
    expOvl   = 12'b0000_0010_0001;
    expNov   = 12'b0000_0010_0000;
    stream10 = 10'b01_0101_1010;
    exp10    = 10'b00_0000_0001;
    stream7  = 7'b101_1010;

    @(posedge clk);
    #1;

    // Reset state
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, "rst0");
    checkOutput("rst0/cnt", {24'b0, cnt}, 32'd0);
    checkOutput("rst0/cnt2", {30'b0, cnt2}, 32'd0);
    checkOutput("rst0/cfgErr", {31'b0, cfgErr}, 32'd0);

    // Default config, overlapping
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b1, stream12[11-i], expOvl[11-i], $sformatf("t1/s%0d", i + 1));
    checkOutput("t1/cnt", {24'b0, cnt}, 32'd2);
    checkOutput("t1/cnt2", {30'b0, cnt2}, 32'd2);

    // Same pattern, non-overlapping
    cntClr = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, "t2/clr");
    cfgWe = 1'b1; cfgPattern = 8'h5A; cfgLen = 4'd7; cfgOverlap = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, "t2/load");
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b1, stream12[11-i], expNov[11-i], $sformatf("t2/s%0d", i + 1));
    checkOutput("t2/cnt", {24'b0, cnt}, 32'd1);

    // Pattern 111 with gaps between valid samples
    cntClr = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, "t3/clr");
    cfgWe = 1'b1; cfgPattern = 8'h07; cfgLen = 4'd3; cfgOverlap = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, "t3/load");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, (i >= 2), $sformatf("t3/v%0d", i + 1));
      applyStimulus(1'b0, 1'b1, 1'b0, $sformatf("t3/gap%0d", i + 1));
    end
    checkOutput("t3/cnt", {24'b0, cnt}, 32'd3);

    // Reset mid-pattern
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, "t4/rstA");
    checkOutput("t4/cntAfterRst", {24'b0, cnt}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, "t4/p1");
    applyStimulus(1'b1, 1'b0, 1'b0, "t4/p2");
    applyStimulus(1'b1, 1'b1, 1'b0, "t4/p3");
    applyStimulus(1'b1, 1'b1, 1'b0, "t4/p4");
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, "t4/rstB");
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, stream10[9-i], exp10[9-i], $sformatf("t4/s%0d", i + 1));
    checkOutput("t4/cnt", {24'b0, cnt}, 32'd1);

    // Rejected configs
    cfgWe = 1'b1; cfgPattern = 8'hFF; cfgLen = 4'd0; cfgOverlap = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, "t5/len0");
    checkOutput("t5/err0", {31'b0, cfgErr}, 32'd1);
    checkOutput("t5/err0b", {31'b0, cfgErr2}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, "t5/idle");
    checkOutput("t5/errClear", {31'b0, cfgErr}, 32'd0);
    cfgWe = 1'b1; cfgPattern = 8'h00; cfgLen = 4'd9; cfgOverlap = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, "t5/len9");
    checkOutput("t5/err9", {31'b0, cfgErr}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, stream7[6-i], (i == 6), $sformatf("t5/s%0d", i + 1));
      if (i == 0) checkOutput("t5/errPulse", {31'b0, cfgErr}, 32'd0);
    end
    checkOutput("t5/cnt", {24'b0, cnt}, 32'd2);

    // Counter saturation and clear-versus-match priority
    cntClr = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, "t6/clr");
    cfgWe = 1'b1; cfgPattern = 8'h01; cfgLen = 4'd1; cfgOverlap = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, "t6/load");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, 1'b1, $sformatf("t6/m%0d", i + 1));
    checkOutput("t6/cnt2at3", {30'b0, cnt2}, 32'd3);
    for (int i = 3; i < 5; i++)
      applyStimulus(1'b1, 1'b1, 1'b1, $sformatf("t6/m%0d", i + 1));
    checkOutput("t6/cnt", {24'b0, cnt}, 32'd5);
    checkOutput("t6/cnt2sat", {30'b0, cnt2}, 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, "t6/miss");
    cntClr = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, "t6/clrMatch");
    checkOutput("t6/cntClrWins", {24'b0, cnt}, 32'd0);
    checkOutput("t6/cnt2ClrWins", {30'b0, cnt2}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, "t6/after");
    checkOutput("t6/cntResume", {24'b0, cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_det_prog.md
# seq_det_prog

Programmable serial bit-pattern detector, the parametrised successor to the fixed 1011010 Mealy detector. It carries a runtime-loadable pattern of 1..MAX_LEN bits, selectable overlapping or non-overlapping detection, a sample-valid qualifier and a saturating match counter. It sits directly on a serial bitstream and feeds a same-cycle match flag plus match statistics to downstream control logic.

## Interface
Parameters:
- MAX_LEN, default 8: maximum pattern length in bits, ≥ 2.
- CNT_W, default 8: match counter width.
- DEF_PATTERN, default 8'b0101_1010: pattern loaded at reset, MAX_LEN wide, low DEF_LEN bits used.
- DEF_LEN, default 7: pattern length loaded at reset.
- DEF_OVERLAP, default 1: detection mode loaded at reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset. Synchronous and active-high.
- cfg_we  in  1  load cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is received first, bit [0] last.
- cfg_len  in  LEN_W = $clog2(MAX_LEN+1)  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping.
- cnt_clr  in  1  clear match_cnt.
- seq_valid  in  1  seq_in holds a sample this cycle.
- seq_in  in  1  serial data.
- flag  out  1  Mealy match: combinational, valid in the same cycle as the final pattern bit.
- match_cnt  out  CNT_W  saturating count of flag pulses.
- cfg_err  out  1  registered one-cycle pulse on a rejected config.

## Operation
- State registers:
  - hist[MAX_LEN-2:0]: shift register of past samples; the newest sample is hist[0].
  - fill: count of valid bits in hist, saturating at MAX_LEN-1.
  - Active config: pat, len, ovl.
  - match_cnt.
- Match condition: flag = seq_valid & ~cfg_we & (fill ≥ len-1) & ({hist[len-2:0], seq_in} == pat[len-1:0]).
  - For len = 1 the condition reduces to seq_in == pat[0].
- On a valid sample with no match: shift seq_in into hist[0] and increment fill (saturating).
- On a match:
  - ovl = 1: shift and increment fill as usual, so a later match can reuse the matched bits.
  - ovl = 0: shift, but set fill to 0, so the next match needs len fresh bits.
- Cycles with seq_valid = 0: hist, fill and flag are held/low; the missing sample does not break a partial match.
- Config load (cfg_we = 1):
  - A legal cfg_len (1..MAX_LEN) loads pat, len and ovl and clears fill. hist contents become don't-care.
  - cfg_len = 0 or cfg_len > MAX_LEN is rejected: the active config, fill and hist are unchanged, and cfg_err pulses in the next cycle.
  - The same-cycle seq_in sample is discarded in both cases.
- match_cnt:
  - Increments when flag = 1 and holds at 2^CNT_W-1 once it reaches it.
  - If cnt_clr and flag are both high in the same cycle, clear wins and match_cnt = 0.
- Reset (rst = 1 at a rising edge, including mid-pattern):
  - pat = DEF_PATTERN, len = DEF_LEN, ovl = DEF_OVERLAP.
  - fill = 0, hist = 0, match_cnt = 0, cfg_err = 0.
  - flag = 0 while rst is high and from the first cycle after reset until fill reaches len-1.

## Timing
- flag has zero latency from seq_in/seq_valid (combinational path). Downstream logic registers it.
- A new config takes effect from the cycle after cfg_we. The earliest possible flag after a config load is len valid samples later.
- cfg_err is asserted one cycle after the rejected cfg_we, for exactly one cycle.
- match_cnt updates one cycle after flag.
- cfg_we and seq_valid in the same cycle: config wins and flag = 0.
- rst overrides cfg_we, cnt_clr and seq_valid.

## Structure
- Package seq_det_pkg contains:
  - The LEN_W derivation (function of MAX_LEN).
  - localparams for the default config.
  - Packed struct cfg_t {pat, len, ovl}.
- One sub-module, seq_det_sat_cnt: a synchronous-clear, saturating up-counter of width CNT_W with inc and clr inputs, clr having priority.

## Test plan
- Reset defaults, ovl = 1, stream 101101011010 → flag on samples 7 and 12; match_cnt = 2.
- cfg_we with pattern 1011010, len = 7, ovl = 0, then the same 12-bit stream → flag on sample 7 only; match_cnt = 1.
- Load len = 3, pattern 111, ovl = 1; stream 11111 with seq_valid low on alternate cycles → flag on valid samples 3, 4 and 5; the gaps do not reset matching.
- Drive 1011 and assert rst mid-pattern, then 010 → no flag. A full 1011010 after reset → flag on its 7th sample.
- cfg_len = 0 and cfg_len = MAX_LEN+1 → cfg_err pulse one cycle later; the default pattern still detects.
- CNT_W = 2 with 5 matches → match_cnt saturates at 3. cnt_clr coinciding with a match → match_cnt = 0.
